// File: rtl/load_extend_unit_if.sv
// Load request, completion and data-memory signals of the load sequencer.
// The slave side is the sequencer; the master side is the pipeline/memory.
interface load_extend_unit_if;
    logic        start;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output start, load_type, addr, mem_ack, mem_rdata,
        input  busy, done, result, err, mem_req, mem_addr
    );

    modport slave (
        input  start, load_type, addr, mem_ack, mem_rdata,
        output busy, done, result, err, mem_req, mem_addr
    );
endinterface

// File: rtl/load_extend_unit.sv
// Multi-cycle MEM-stage load sequencer: word read over req/ack, then
// big-endian byte/halfword select with sign or zero extension.
module load_extend_unit #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input logic               clk,
    input logic               rst_n,
    load_extend_unit_if.slave bus
);
    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE, CHECK, REQ, EXT, DONE
    } state_t;

    state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] result_q, result_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic        illegal, misal;
    logic [15:0] half;
    logic [7:0]  bsel;
    logic [31:0] ext;

    assign illegal = type_q > LT_LBU;
    assign misal   = ((type_q == LT_LW) && (addr_q[1:0] != 2'b00))
                   || (((type_q == LT_LH) || (type_q == LT_LHU))
                       && addr_q[0]);
    assign cnt_inc = cnt + 1'b1;

    // Big-endian lanes: the lowest address holds the most significant byte.
    always_comb begin
        half = addr_q[1] ? word_q[15:0] : word_q[31:16];
        bsel = word_q[31:24];
        unique case (addr_q[1:0])
            2'b00: bsel = word_q[31:24];
            2'b01: bsel = word_q[23:16];
            2'b10: bsel = word_q[15:8];
            2'b11: bsel = word_q[7:0];
            default: bsel = word_q[31:24];
        endcase
        ext = word_q;
        unique case (1'b1)
            type_q == LT_LH:  ext = {{16{half[15]}}, half};
            type_q == LT_LHU: ext = {16'h0000, half};
            type_q == LT_LB:  ext = {{24{bsel[7]}}, bsel};
            type_q == LT_LBU: ext = {24'h000000, bsel};
            default:          ext = word_q;
        endcase
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        addr_d     = addr_q;
        type_d     = type_q;
        word_d     = word_q;
        result_d   = result_q;
        err_d      = err_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.addr;
                    type_d  = bus.load_type;
                    err_d   = 2'b00;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (illegal || misal) begin
                    err_d    = illegal ? 2'b11 : 2'b01;
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[31:2], 2'b00};
                    cnt_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Ack is checked first so it beats a same-cycle timeout.
                if (mem_req_q && bus.mem_ack) begin
                    word_d    = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = EXT;
                end else if (cnt == TMO) begin
                    err_d    = 2'b10;
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        mem_req_d = 1'b0;
                    end
                end
            end
            EXT: begin
                result_d = ext;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CHECK) || (state_d == REQ)
              || (state_d == EXT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            type_q     <= '0;
            word_q     <= '0;
            result_q   <= '0;
            err_q      <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            word_q     <= word_d;
            result_q   <= result_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.err      = err_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Multi-cycle load sequencer for the MEM stage.
- Takes a load request (LW/LH/LHU/LB/LBU) and issues a word-aligned read to data memory over a req/ack handshake.
- Selects the addressed byte or halfword (big-endian) and sign- or zero-extends it to 32 bits.
- Busy stalls the pipeline while a load is in flight; misaligned, illegal and timed-out accesses are flagged.

Parameters:
- TIMEOUT_CYC, 15: max cycles MemReq may stay high without MemAck before aborting (1..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  load request, sampled in IDLE only.
- LoadType  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101-111 illegal.
- Addr  input  32  byte address, captured on accepted Start.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle completion pulse.
- Result  output  32  extended load data, held until the next accepted Start.
- Err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal type; valid with Done, held with Result.
- MemReq  output  1  memory read request.
- MemAddr  output  32  {Addr[31:2],2'b00}, stable while MemReq is high.
- MemAck  input  1  memory data valid, single-cycle.
- MemRData  input  32  memory read word, valid with MemAck.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state IDLE; Busy, Done, MemReq = 0; Result = 0; Err = 00; MemAddr = 0; timeout counter = 0.
  - Takes effect immediately mid-operation; a MemAck arriving during or after reset is ignored.
- States: IDLE, CHECK, REQ, EXT, DONE.
- IDLE:
  - On Start=1: latch Addr and LoadType, clear Err, go to CHECK.
  - Start=0: stay in IDLE.
- CHECK (Busy=1):
  - LoadType illegal -> Err=11.
  - LW with Addr[1:0]!=00 -> Err=01.
  - LH/LHU with Addr[0]=1 -> Err=01.
  - Illegal type takes priority over misalignment.
  - On any error: Result=0, go to DONE; no memory request is ever issued.
  - Otherwise: assert MemReq, clear counter, go to REQ.
- REQ (Busy=1, MemReq=1):
  - Counter increments each cycle.
  - MemAck=1: latch MemRData, drop MemReq next cycle, go to EXT.
  - Counter reaches TIMEOUT_CYC with no ack: drop MemReq, Err=10, Result=0, go to DONE.
  - MemAck in the same cycle the counter hits TIMEOUT_CYC: the ack wins, no timeout.
- EXT (Busy=1): compute Result from the latched word W and Addr[1:0]; go to DONE.
  - LW: W.
  - LH/LHU, Addr[1]=0 -> W[31:16]; Addr[1]=1 -> W[15:0].
  - LB/LBU, Addr[1:0] 00 -> W[31:24], 01 -> W[23:16], 10 -> W[15:8], 11 -> W[7:0].
  - LH and LB replicate bit 15 / bit 7 of the selected field into the upper bits.
  - LHU and LBU zero-fill the upper bits.
- DONE: Done=1 for exactly one cycle, Busy=0 in that cycle, return to IDLE.
- Start handling outside IDLE:
  - Start asserted in any state other than IDLE is ignored.
  - Start asserted in the DONE cycle is also ignored; the earliest accepted next Start is the cycle after Done.
- Stray inputs: MemAck outside REQ is ignored; MemRData is only sampled on MemAck in REQ.
- Latency, with Start accepted at cycle 0:
  - Cycle 1 CHECK, MemReq high from cycle 2.
  - Ack at cycle 2+k (k>=0) gives EXT at 3+k and Done at 4+k.
  - Error paths: Done at cycle 2.
  - Timeout path: Done at cycle 2+TIMEOUT_CYC+1.
- Outputs Busy, Done, MemReq and Err are registered; none combinationally depends on Start or MemAck.

Test Plan:
- LB, Addr=0x1003, MemRData=0x12345680, ack 2 cycles after MemReq rises -> MemAddr=0x1000, Result=0xFFFFFF80, Err=00, Done exactly 6 cycles after Start.
- LBU, same Addr and data -> Result=0x00000080. LHU, Addr=0x2000, data 0xBEEF0000, ack immediate -> Result=0x0000BEEF. LH on the same -> 0xFFFFBEEF.
- LW, Addr=0x3002 -> Err=01, Result=0, MemReq never asserted, Done at cycle 2. LoadType=111 with Addr=0x3001 -> Err=11.
- LW, Addr=0x4000, MemAck never asserted (TIMEOUT_CYC=15) -> MemReq high 15 cycles, then Err=10, Result=0, Done. Repeat with ack on the 15th cycle -> Err=00, Result=MemRData.
- Start pulsed during REQ and during the DONE cycle -> ignored, exactly one Done produced. Stray MemAck in IDLE -> Result unchanged.
- Reset_n pulled low during REQ -> MemReq, Busy, Result, Err drop to 0 immediately. Ack arriving after release -> ignored. Next LW (Addr=0x0, data 0xCAFEBABE) -> Result=0xCAFEBABE.
